// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode 0 slave, MSB first, fixed 8-bit frames.
//
// SCLK, SS and MOSI are brought into the i_clk domain through 2-flop synchronisers.
// A third flop on SCLK/SS gives the previous level, and the edge pulses themselves are
// registered, so a pin edge becomes visible three i_clk cycles after it happens.
// Received bytes appear on rx_byte with a one-cycle rx_dv strobe. The byte to send is
// written into a single-entry holding buffer that is copied into the TX shift register
// at the start of every frame (LOAD), including back-to-back frames under one SS low.
//
// Ports:
//   i_clk      system clock, at least 8x the SCLK frequency
//   reset      asynchronous active-high reset
//   i_spi_clk  SPI clock from the master (asynchronous, idles low)
//   i_ss       slave select, active low (asynchronous)
//   i_mosi     serial data from the master (asynchronous)
//   o_miso     serial data to the master
//   tx_byte    byte to transmit in the next frame
//   tx_dv      one-cycle write strobe for tx_byte
//   tx_ready   high while the holding buffer is empty
//   rx_byte    last complete received byte
//   rx_dv      one-cycle strobe: rx_byte is new
//   err        only with SPI_SLAVE_STATUS_EN defined: sticky status,
//              bit0 = underrun (LOAD found the buffer empty),
//              bit1 = overwrite (tx_dv while tx_ready was low)
//
// Build option: define SPI_SLAVE_STATUS_EN to add the err port and its logic.

module spi_slave (
   input  logic       i_clk,
   input  logic       reset,
   input  logic       i_spi_clk,
   input  logic       i_ss,
   input  logic       i_mosi,
   output logic       o_miso,
   input  logic [7:0] tx_byte,
   input  logic       tx_dv,
   output logic       tx_ready,
   output logic [7:0] rx_byte,
   output logic       rx_dv
`ifdef SPI_SLAVE_STATUS_EN
   ,
   output logic [1:0] err
`endif
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

   // Synchronisers and edge detection
   logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
   logic ss_meta_q, ss_sync_q, ss_dly_q;
   logic mosi_meta_q, mosi_sync_q;
   logic sclk_rise_d, sclk_rise_q, sclk_fall_d, sclk_fall_q;
   logic ss_fall_d, ss_fall_q, ss_rise_d, ss_rise_q;

   // Frame state
   state_e     state_d, state_q;
   logic [2:0] cnt_d, cnt_q;
   logic       wrap_d, wrap_q;       // 8th bit received, next SCLK fall starts LOAD
   logic [7:0] rx_shift_d, rx_shift_q;
   logic [7:0] tx_shift_d, tx_shift_q;
   logic       miso_d, miso_q;
   logic [7:0] rx_byte_d, rx_byte_q;
   logic       rx_dv_d, rx_dv_q;

   // Holding buffer
   logic [7:0] buf_d, buf_q;
   logic       tx_ready_d, tx_ready_q;
   logic       load_st;
   logic       tx_accept;

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_dly_q  <= 1'b0;
         // SS resets to its idle (deasserted) level so no false ss_fall follows reset
         ss_meta_q   <= 1'b1;
         ss_sync_q   <= 1'b1;
         ss_dly_q    <= 1'b1;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         ss_fall_q   <= 1'b0;
         ss_rise_q   <= 1'b0;
      end else begin
         sclk_meta_q <= i_spi_clk;
         sclk_sync_q <= sclk_meta_q;
         sclk_dly_q  <= sclk_sync_q;
         ss_meta_q   <= i_ss;
         ss_sync_q   <= ss_meta_q;
         ss_dly_q    <= ss_sync_q;
         mosi_meta_q <= i_mosi;
         mosi_sync_q <= mosi_meta_q;
         sclk_rise_q <= sclk_rise_d;
         sclk_fall_q <= sclk_fall_d;
         ss_fall_q   <= ss_fall_d;
         ss_rise_q   <= ss_rise_d;
      end
   end

   always_comb begin
      sclk_rise_d = sclk_sync_q & ~sclk_dly_q;
      sclk_fall_d = ~sclk_sync_q & sclk_dly_q;
      ss_fall_d   = ~ss_sync_q & ss_dly_q;
      ss_rise_d   = ss_sync_q & ~ss_dly_q;
   end

   assign load_st = (state_q == StLoad);
   // During LOAD the buffer is being emptied, so a write in that cycle always lands.
   assign tx_accept = tx_dv & (tx_ready_q | load_st);

   always_comb begin
      buf_d      = buf_q;
      tx_ready_d = tx_ready_q;
      if (load_st) begin
         tx_ready_d = 1'b1;
      end
      if (tx_accept) begin
         buf_d      = tx_byte;
         tx_ready_d = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wrap_d     = wrap_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      miso_d     = miso_q;
      rx_byte_d  = rx_byte_q;
      rx_dv_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            miso_d = 1'b0;
            cnt_d  = 3'd0;
            wrap_d = 1'b0;
            if (ss_fall_q) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            // Empty buffer: send zeros for this frame
            tx_shift_d = tx_ready_q ? 8'h00 : buf_q;
            miso_d     = tx_shift_d[7];
            cnt_d      = 3'd0;
            wrap_d     = 1'b0;
            state_d    = StShift;
         end
         StShift: begin
            if (sclk_rise_q) begin
               rx_shift_d = {rx_shift_q[6:0], mosi_sync_q};
               cnt_d      = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  rx_byte_d = {rx_shift_q[6:0], mosi_sync_q};
                  rx_dv_d   = 1'b1;
                  wrap_d    = 1'b1;
               end
            end
            if (sclk_fall_q) begin
               if (wrap_q) begin
                  wrap_d  = 1'b0;
                  state_d = StLoad;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  miso_d     = tx_shift_q[6];
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // SS deassertion aborts any frame; the partial RX byte is dropped
      if (ss_rise_q) begin
         state_d    = StIdle;
         cnt_d      = 3'd0;
         wrap_d     = 1'b0;
         miso_d     = 1'b0;
         rx_shift_d = 8'h00;
         tx_shift_d = 8'h00;
      end
   end

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= 3'd0;
         wrap_q     <= 1'b0;
         rx_shift_q <= 8'h00;
         tx_shift_q <= 8'h00;
         miso_q     <= 1'b0;
         rx_byte_q  <= 8'h00;
         rx_dv_q    <= 1'b0;
         buf_q      <= 8'h00;
         tx_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wrap_q     <= wrap_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         miso_q     <= miso_d;
         rx_byte_q  <= rx_byte_d;
         rx_dv_q    <= rx_dv_d;
         buf_q      <= buf_d;
         tx_ready_q <= tx_ready_d;
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   logic [1:0] err_d, err_q;

   always_comb begin
      err_d = err_q;
      if (load_st && tx_ready_q) begin
         err_d[0] = 1'b1;
      end
      if (tx_dv && !tx_ready_q && !load_st) begin
         err_d[1] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         err_q <= 2'b00;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

   assign o_miso   = miso_q;
   assign tx_ready = tx_ready_q;
   assign rx_byte  = rx_byte_q;
   assign rx_dv    = rx_dv_q;

endmodule
